// File: rtl/iomem_timer_pkg.sv
// Shared definitions for the iomem_timer block: register offsets, CTRL and
// STATUS bit positions, and the byte-strobe merge helper.
package iomem_timer_pkg;

    // Word offsets inside the register window (addr[4:2])
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_RELOAD   = 3'd2;
    localparam logic [2:0] REG_COUNT    = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;
    localparam logic [2:0] REG_CAPTURE  = 3'd5;

    // CTRL bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    // STATUS bit indices
    localparam int STAT_PENDING     = 0;
    localparam int STAT_CAP_PENDING = 1;

    // Replace only the bytes whose strobe is set; other bytes keep old_v.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/iomem_timer_prescaler.sv
// Prescaler for iomem_timer: counts enabled cycles and emits a one-cycle
// tick whenever the counter reaches the programmed PRESCALE value.
module iomem_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == prescale_i);

    // Next prescale count: cleared while disabled, wraps to zero on a tick
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

    // Prescale counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped down-counting timer on the iomem bus with a
// level interrupt on expiry. Optional input-capture channel is built when
// the macro TIMER_CAPTURE_EN is defined.
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16,
    parameter int          COUNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic        capture_in
`endif
);

    logic                  ready_q;
    logic [31:0]           rdata_q;
    logic                  irq_q, irq_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [COUNT_W-1:0]    reload_q, reload_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic                  pending_q, pending_d;

    logic                  sel_s;
    logic                  access_s;
    logic                  mapped_s;
    logic                  wr_s;
    logic [2:0]            offset_s;
    logic [31:0]           rd_s;
    logic [1:0]            w1c_s;
    logic                  tick_s;
    logic                  expire_s;
    logic                  cap_pending_s;

`ifdef TIMER_CAPTURE_EN
    logic [2:0]            cap_sync_q;
    logic                  cap_rise_s;
    logic [COUNT_W-1:0]    capture_q, capture_d;
    logic                  cap_pending_q, cap_pending_d;
    logic                  unused_s;

    assign cap_rise_s    = cap_sync_q[1] && !cap_sync_q[2];
    assign cap_pending_s = cap_pending_q;
    assign unused_s      = ^iomem_addr[1:0];
`else
    logic                  unused_s;

    assign cap_pending_s = 1'b0;
    assign unused_s      = ^{iomem_addr[1:0], w1c_s[1]};
`endif

    assign sel_s    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign access_s = sel_s && !ready_q;
    assign mapped_s = (iomem_addr[7:5] == 3'd0);
    assign offset_s = iomem_addr[4:2];
    assign wr_s     = access_s && mapped_s && (iomem_wstrb != 4'd0);
    assign w1c_s    = iomem_wstrb[0] ? iomem_wdata[1:0] : 2'b00;

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = irq_q;

    iomem_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .en_i       (ctrl_q[CTRL_EN]),
        .prescale_i (prescale_q),
        .tick_o     (tick_s)
    );

    // Read mux: live register values, zero for unmapped offsets
    always_comb begin
        rd_s = 32'd0;
        if (mapped_s) begin
            case (offset_s)
                REG_CTRL:     rd_s = 32'(ctrl_q);
                REG_PRESCALE: rd_s = 32'(prescale_q);
                REG_RELOAD:   rd_s = 32'(reload_q);
                REG_COUNT:    rd_s = 32'(count_q);
                REG_STATUS:   rd_s = {30'd0, cap_pending_s, pending_q};
`ifdef TIMER_CAPTURE_EN
                REG_CAPTURE:  rd_s = 32'(capture_q);
`endif
                default:      rd_s = 32'd0;
            endcase
        end else begin
            rd_s = 32'd0;
        end
    end

    // Timer next state: tick/expiry first, then bus writes take precedence
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        expire_s   = 1'b0;

        if (tick_s) begin
            if (count_q == '0) begin
                expire_s = 1'b1;
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = reload_q;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end else begin
                count_d = count_q - {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_d = count_q;
        end

        if (wr_s) begin
            case (offset_s)
                REG_CTRL: begin
                    ctrl_d = 3'(merge_bytes(32'(ctrl_q), iomem_wdata, iomem_wstrb));
                    // A one-shot expiry in the same cycle still stops the timer
                    if (expire_s && !ctrl_q[CTRL_AUTO]) begin
                        ctrl_d[CTRL_EN] = 1'b0;
                    end else begin
                        ctrl_d[CTRL_EN] = ctrl_d[CTRL_EN];
                    end
                end
                REG_PRESCALE: prescale_d = PRESCALE_W'(merge_bytes(32'(prescale_q), iomem_wdata, iomem_wstrb));
                REG_RELOAD:   reload_d   = COUNT_W'(merge_bytes(32'(reload_q), iomem_wdata, iomem_wstrb));
                REG_COUNT:    count_d    = COUNT_W'(merge_bytes(32'(count_q), iomem_wdata, iomem_wstrb));
                default:      ctrl_d     = ctrl_d;
            endcase
        end else begin
            ctrl_d = ctrl_d;
        end

        // Expiry sets pending even if software clears it in the same cycle
        pending_d = (pending_q && !(wr_s && (offset_s == REG_STATUS) && w1c_s[STAT_PENDING]))
                    || expire_s;
    end

`ifdef TIMER_CAPTURE_EN
    // Capture channel next state: latch COUNT and flag on a synced rising edge
    always_comb begin
        capture_d     = capture_q;
        cap_pending_d = (cap_pending_q && !(wr_s && (offset_s == REG_STATUS) && w1c_s[STAT_CAP_PENDING]))
                        || cap_rise_s;
        if (cap_rise_s) begin
            capture_d = count_q;
        end else begin
            capture_d = capture_q;
        end
        irq_d = (pending_d || cap_pending_d) && ctrl_d[CTRL_IE];
    end

    // Capture pin synchroniser, edge history and capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_sync_q    <= 3'd0;
            capture_q     <= '0;
            cap_pending_q <= 1'b0;
        end else begin
            cap_sync_q    <= {cap_sync_q[1:0], capture_in};
            capture_q     <= capture_d;
            cap_pending_q <= cap_pending_d;
        end
    end
`else
    // Interrupt level from the expiry flag alone
    always_comb begin
        irq_d = pending_d && ctrl_d[CTRL_IE];
    end
`endif

    // Bus handshake, read data and timer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            irq_q      <= 1'b0;
            ctrl_q     <= 3'd0;
            prescale_q <= '0;
            reload_q   <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
        end else begin
            ready_q    <= access_s;
            rdata_q    <= access_s ? rd_s : 32'd0;
            irq_q      <= irq_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
        end
    end

endmodule
